mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO register width (even, >=8).
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have start  input  1  request strobe; sampled only while busy=0.
REQ-005 SHALL have op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
REQ-006 SHALL have op_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
REQ-007 SHALL have op_b  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have busy  output  1  high while an operation is in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse on the edge HI/LO take a MULT/DIV result.
REQ-010 SHALL have dz  output  1  divide-by-zero flag of the last completed DIV/DIVU; held until the next completion.
REQ-011 SHALL have hi  output  WIDTH  HI register (mult upper half / remainder).
REQ-012 SHALL have lo  output  WIDTH  LO register (mult lower half / quotient).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FIX; only IDLE accepts start.
REQ-014 SHALL, on start in IDLE with MTHI/MTLO, load hi/lo from op_a at that edge, stay IDLE, keep busy=0, not pulse done.
REQ-015 SHALL, on start in IDLE with MULT/MULTU/DIV/DIVU and nonzero divisor for divides, capture operands, go RUN, assert busy from the next cycle.
REQ-016 SHALL execute multiply as radix-2 shift-add and divide as restoring shift-subtract, one bit per cycle, WIDTH cycles in RUN.
REQ-017 SHALL leave RUN to IDLE (unsigned op) or FIX (signed op), FIX lasting one cycle applying sign correction.
REQ-018 SHALL give latency start-edge to done of WIDTH cycles unsigned, WIDTH+1 signed; done and hi/lo update on the same edge, busy falls with done.
REQ-019 SHALL produce the full 2*WIDTH product as {hi,lo}; divide gives lo=quotient, hi=remainder.
REQ-020 SHALL truncate signed quotient toward zero, remainder takes dividend sign; MIN/-1 yields lo=MIN, hi=0.
REQ-021 SHALL, on DIV/DIVU with op_b=0, skip RUN, set hi=op_a, lo=all ones, dz=1, pulse done at the next edge with busy never asserted.
REQ-022 SHALL ignore start, op, op_a, op_b while busy=1; hi/lo keep prior values until done.
REQ-023 SHALL treat op codes 110/111 as no-op with no state change.

Reset
REQ-024 SHALL on rst_n low immediately force state IDLE, busy=0, done=0, dz=0, hi=0, lo=0, discarding any in-flight operation.
REQ-025 SHALL accept a new start on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with MDU_SIGNED_EN defined, support signed MULT/DIV per REQ-017/020 using FIX.
REQ-027 SHALL, without MDU_SIGNED_EN, execute MULT as MULTU and DIV as DIVU, never enter FIX, latency always WIDTH.

Structure
REQ-028 SHALL place op encodings and FSM state enum in shared package mdu_pkg.
REQ-029 SHALL contain one sub-module mdu_div_step: combinational one-bit restoring divide step (remainder, quotient in; remainder, quotient out).

Verification (WIDTH=32)
REQ-030 SHALL check MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done after 32 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL check DIV a=-7 b=2 (MDU_SIGNED_EN) -> done after 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; without macro lo=0x7FFFFFFC, hi=0x00000001.
REQ-032 SHALL check DIVU a=5 b=0 -> done next edge, dz=1, hi=5, lo=0xFFFFFFFF, busy stays 0.
REQ-033 SHALL check start with MTLO a=0x1234 issued during busy -> ignored; after done, MTLO a=0x1234 -> lo=0x1234 next edge, hi unchanged, no done.
REQ-034 SHALL check rst_n pulsed low at cycle 10 of MULTU -> busy, done, hi, lo all 0 immediately; next start completes normally.
REQ-035 SHALL check DIV a=0x80000000 b=0xFFFFFFFF (MDU_SIGNED_EN) -> lo=0x80000000, hi=0, dz=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One bit of restoring division: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    // rem < dvsr holds, so the W+1-bit difference sign is a valid borrow
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvsr};
    assign ge     = ~diff[WIDTH];
    assign rem_o  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_o  = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle.
// Define MDU_SIGNED_EN to enable signed MULT/DIV via a one-cycle FIX sign correction.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               last;
    logic               is_div, sgn, neg_q, neg_r;
    logic [WIDTH-1:0]   acc, wlo, opb_r;

    logic               req_mdu, req_div, req_sgn, dz_req;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   m_hi, m_lo, d_hi, d_lo, nx_hi, nx_lo;
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   fx_hi, fx_lo;

    assign req_mdu = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign req_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_SIGNED_EN
    assign req_sgn = (op == OP_MULT) || (op == OP_DIV);
`else
    assign req_sgn = 1'b0;
`endif
    assign dz_req = req_div && (op_b == '0);
    assign a_mag  = (req_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag  = (req_sgn && op_b[WIDTH-1]) ? -op_b : op_b;

    assign busy = (state != S_IDLE);
    assign last = (cnt == CW'(WIDTH - 1));

    // Shift-add: {acc, wlo} holds partial product above the remaining multiplier bits
    assign sum  = {1'b0, acc} + (wlo[0] ? {1'b0, opb_r} : '0);
    assign m_hi = sum[WIDTH:1];
    assign m_lo = {sum[0], wlo[WIDTH-1:1]};

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (acc),
        .quo   (wlo),
        .dvsr  (opb_r),
        .rem_o (d_hi),
        .quo_o (d_lo)
    );

    assign nx_hi  = is_div ? d_hi : m_hi;
    assign nx_lo  = is_div ? d_lo : m_lo;

    assign prod_n = -{acc, wlo};
    assign fx_hi  = is_div ? (neg_r ? -acc : acc) : (neg_q ? prod_n[2*WIDTH-1:WIDTH] : acc);
    assign fx_lo  = is_div ? (neg_q ? -wlo : wlo) : (neg_q ? prod_n[WIDTH-1:0] : wlo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start && req_mdu && !dz_req) state_nx = S_RUN;
            S_RUN:   if (last) state_nx = sgn ? S_FIX : S_IDLE;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            wlo    <= '0;
            opb_r  <= '0;
            done   <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    case (op)
                        OP_MTHI: hi <= op_a;
                        OP_MTLO: lo <= op_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            if (dz_req) begin
                                hi   <= op_a;
                                lo   <= '1;
                                dz   <= 1'b1;
                                done <= 1'b1;
                            end else begin
                                acc    <= '0;
                                wlo    <= a_mag;
                                opb_r  <= b_mag;
                                cnt    <= '0;
                                is_div <= req_div;
                                sgn    <= req_sgn;
                                neg_q  <= req_sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                neg_r  <= req_sgn && op_a[WIDTH-1];
                            end
                        end
                        default: ;
                    endcase
                end
                S_RUN: begin
                    acc <= nx_hi;
                    wlo <= nx_lo;
                    cnt <= cnt + 1'b1;
                    if (last && !sgn) begin
                        hi   <= nx_hi;
                        lo   <= nx_lo;
                        done <= 1'b1;
                        if (is_div) dz <= 1'b0;
                    end
                end
                S_FIX: begin
                    hi   <= fx_hi;
                    lo   <= fx_lo;
                    done <= 1'b1;
                    if (is_div) dz <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed table-driven bench for mdu_iter (WIDTH=32); expectations follow MDU_SIGNED_EN.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;
    localparam int N = 11;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
        int          elat;
        logic        chk_dz;
        logic        edz;
    } vec_t;

    vec_t tbl [N];

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic bsy);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b111;
        bsy = busy;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic bsy;

        tbl[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32, 1'b0, 1'b0};
        tbl[1]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 32, 1'b0, 1'b0};
        tbl[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       32, 1'b1, 1'b0};
        tbl[3]  = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0,  1'b1, 1'b1};
        tbl[4]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 32, 1'b1, 1'b0};
        tbl[5]  = '{OP_DIVU,  32'd3,        32'd10,       32'd3,        32'd0,        32, 1'b1, 1'b0};
`ifdef MDU_SIGNED_EN
        tbl[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1, 1'b0};
        tbl[7]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 33, 1'b0, 1'b0};
        tbl[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1, 1'b0};
        tbl[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1, 1'b0};
`else
        tbl[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 32, 1'b1, 1'b0};
        tbl[7]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 32, 1'b0, 1'b0};
        tbl[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32, 1'b1, 1'b0};
        tbl[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000007, 32'h00000000, 32, 1'b1, 1'b0};
`endif
        tbl[10] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0,  1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = 3'b111; op_a = '0; op_b = '0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz",   {63'd0, dz},   64'd0);
        chk("rst_hi",   {32'd0, hi},   64'd0);
        chk("rst_lo",   {32'd0, lo},   64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bsy);
            chk($sformatf("v%0d_lat", i),  64'(lat), 64'(tbl[i].elat));
            chk($sformatf("v%0d_busy", i), {63'd0, bsy}, {63'd0, (tbl[i].elat != 0)});
            chk($sformatf("v%0d_hi", i),   {32'd0, hi}, {32'd0, tbl[i].ehi});
            chk($sformatf("v%0d_lo", i),   {32'd0, lo}, {32'd0, tbl[i].elo});
            if (tbl[i].chk_dz) chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, tbl[i].edz});
        end

        // MTLO presented mid-operation must be ignored
        @(negedge clk); start = 1'b1; op = OP_MULTU; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1; start = 1'b0; lat = 0;
        repeat (4) begin @(posedge clk); #1; lat++; end
        @(negedge clk); start = 1'b1; op = OP_MTLO; op_a = 32'h1234;
        @(posedge clk); #1; lat++; start = 1'b0; op = 3'b111;
        chk("busy_mtlo_lo",   {32'd0, lo}, {32'd0, tbl[N-1].elo});
        chk("busy_mtlo_busy", {63'd0, busy}, 64'd1);
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("ign_lat", 64'(lat), 64'd32);
        chk("ign_hi",  {32'd0, hi}, 64'd0);
        chk("ign_lo",  {32'd0, lo}, 64'd12);
        @(posedge clk); #1;
        chk("done_pulse", {63'd0, done}, 64'd0);

        @(negedge clk); start = 1'b1; op = OP_MTLO; op_a = 32'h1234;
        @(posedge clk); #1; start = 1'b0; op = 3'b111;
        chk("mtlo_lo",   {32'd0, lo}, 64'h1234);
        chk("mtlo_hi",   {32'd0, hi}, 64'd0);
        chk("mtlo_done", {63'd0, done}, 64'd0);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);

        @(negedge clk); start = 1'b1; op = OP_MTHI; op_a = 32'hABCD;
        @(posedge clk); #1; start = 1'b0; op = 3'b111;
        chk("mthi_hi", {32'd0, hi}, 64'hABCD);
        chk("mthi_lo", {32'd0, lo}, 64'h1234);

        @(negedge clk); start = 1'b1; op = 3'b110; op_a = 32'hFFFF; op_b = 32'd1;
        @(posedge clk); #1; start = 1'b0; op = 3'b111;
        @(posedge clk); #1;
        chk("nop_hi",   {32'd0, hi}, 64'hABCD);
        chk("nop_lo",   {32'd0, lo}, 64'h1234);
        chk("nop_busy", {63'd0, busy}, 64'd0);
        chk("nop_done", {63'd0, done}, 64'd0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk); start = 1'b1; op = OP_MULTU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
        @(posedge clk); #1; start = 1'b0; op = 3'b111;
        repeat (9) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_dz",   {63'd0, dz},   64'd0);
        chk("arst_hi",   {32'd0, hi},   64'd0);
        chk("arst_lo",   {32'd0, lo},   64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(OP_MULTU, 32'd6, 32'd7, lat, bsy);
        chk("post_lat", 64'(lat), 64'd32);
        chk("post_hi",  {32'd0, hi}, 64'd0);
        chk("post_lo",  {32'd0, lo}, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
